// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// The full result is computed at issue into a shadow and committed when the busy countdown expires.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   hi_reg, hi_next, lo_reg, lo_next;
  logic [31:0]   res_hi_reg, res_hi_next, res_lo_reg, res_lo_next;

  logic [63:0] mul_a, mul_b, prod, result;
  logic        sdiv;
  logic [31:0] dvd, dvs, uq, ur, quot, rem;

  // A signed 32x32 product equals the low 64 bits of the sign-extended operands' product,
  // so one multiplier serves both mult and multu.
  always_comb begin
    mul_a = (mdu_op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
    mul_b = (mdu_op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = mul_a * mul_b;

    // Signed divide runs on magnitudes; -2^31 / -1 falls out naturally as 0x80000000 rem 0.
    sdiv = (mdu_op == OP_DIV);
    dvd  = (sdiv && a[31]) ? -a : a;
    dvs  = (sdiv && b[31]) ? -b : b;
    uq   = (dvs == 32'd0) ? 32'hFFFF_FFFF : dvd / dvs;
    ur   = (dvs == 32'd0) ? dvd : dvd % dvs;
    quot = (sdiv && (a[31] ^ b[31])) ? -uq : uq;
    rem  = (sdiv && a[31]) ? -ur : ur;

    if (mdu_op == OP_MULT || mdu_op == OP_MULTU)
      result = prod;
    else if (b == 32'd0)
      result = {a, 32'hFFFF_FFFF};
    else
      result = {rem, quot};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      res_hi_reg <= '0;
      res_lo_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      res_hi_reg <= res_hi_next;
      res_lo_reg <= res_lo_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    res_hi_next = res_hi_reg;
    res_lo_next = res_lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              res_hi_next = result[63:32];
              res_lo_next = result[31:0];
              cnt_next    = (mdu_op == OP_MULT || mdu_op == OP_MULTU) ?
                            CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
              state_next  = RUN;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Issue strobes are ignored here; only the countdown advances.
        if (cnt_reg <= CW'(1)) begin
          cnt_next   = '0;
          hi_next    = res_hi_reg;
          lo_next    = res_lo_reg;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (cnt_reg != '0);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed test-plan cases plus randomized ops against an arithmetic reference model.
module tb_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain SV integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx, sy, q, r;
    int unsigned ux, uy;
    longint pl;
    longint unsigned pu;
    sx = x; sy = y; ux = x; uy = y;
    case (op)
      3'd1: begin pl = longint'(sx) * longint'(sy); return pl; end
      3'd2: begin pu = longint'(ux) * longint'(uy); return pu; end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy; r = sx % sy;
        return {r, q};
      end
      3'd4: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {ux % uy, ux / uy};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Entered and left on a negedge. Optionally injects ignored mtlo/multu strobes while busy.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit inject);
    int n, lat;
    logic [63:0] r;
    check("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; mdu_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    lat = (op == 3'd1 || op == 3'd2) ? 5 : (op == 3'd3 || op == 3'd4) ? 10 : 0;
    if (lat != 0) begin
      check("hold_hi", hi, m_hi);
      check("hold_lo", lo, m_lo);
    end
    n = 0;
    while (busy && n < 64) begin
      if (inject && n == 1) begin
        start = 1'b1; mdu_op = 3'd6; a = $urandom;
      end else if (inject && n == 2) begin
        start = 1'b1; mdu_op = 3'd2; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0; mdu_op = 3'd0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", n, lat);
    if (lat != 0) begin
      r = ref_result(op, x, y);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end else if (op == 3'd5) m_hi = x;
    else if (op == 3'd6) m_lo = x;
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op, x, y, n, hi, lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; a = 32'd0; b = 32'd0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("tp_mult_hi", hi, 32'hFFFF_FFFF);
    check("tp_mult_lo", lo, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("tp_multu_hi", hi, 32'h0000_0001);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("tp_div_lo", lo, 32'hFFFF_FFFD);
    check("tp_div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd7, 32'd2, 1'b0);
    check("tp_divu_lo", lo, 32'd3);
    check("tp_divu_hi", hi, 32'd1);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    check("tp_div0_lo", lo, 32'hFFFF_FFFF);
    check("tp_div0_hi", hi, 32'h1234_5678);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("tp_ovf_lo", lo, 32'h8000_0000);
    check("tp_ovf_hi", hi, 32'd0);
    run_op(3'd5, 32'hCAFE_BABE, 32'd0, 1'b0);
    check("tp_mthi", hi, 32'hCAFE_BABE);
    run_op(3'd1, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);

    // Back-to-back: the div is issued in the very first non-busy cycle.
    run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op(3'd3, 32'd1000, 32'hFFFF_FFFD, 1'b0);

    // Asynchronous reset mid-div must clear state at once and suppress the commit.
    check("pre_rst_lo_nonzero", {31'd0, lo == 32'd0}, 32'd0);
    start = 1'b1; mdu_op = 3'd3; a = 32'h5555_5555; b = 32'd3;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);
    run_op(3'd1, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);

    repeat (60) begin
      rop = 3'($urandom_range(0, 7));
      rx  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(1, 16));
        default: ry = $urandom;
      endcase
      run_op(rop, rx, ry, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
